// File: rtl/apu_mixer_pkg.sv
// Shared types for the APU mixer sequencer: mixer width, FSM states and the
// command word layout {frames, mask} stored in the command FIFO.
package apu_mixer_pkg;

  localparam int MIXER_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/mixer_cmd_fifo.sv
// Synchronous command FIFO for the mixer sequencer; flush clears it like reset.
// Head entry is presented combinationally from the storage array.
module mixer_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = i_wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/apu_mixer_sequencer.sv
// Frame-synchronous mixer mask sequencer for the APU channel-enable input.
// APU_MIXER_SEQ_HOLD_LAST_EN: keep the last mask after the final command expires.
module apu_mixer_sequencer
  import apu_mixer_pkg::*;
#(
  parameter int                 DEPTH        = 4,
  parameter int                 FRAME_W      = 8,
  parameter logic [MIXER_W-1:0] DEFAULT_MASK = 4'b1111
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [MIXER_W-1:0]     i_cmd_mask,
  input  logic [FRAME_W-1:0]     i_cmd_frames,
  input  logic                   i_frame_pulse,
  output logic [MIXER_W-1:0]     o_mixer,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int CMD_W = FRAME_W + MIXER_W;

  // Command handshake: a command transfers on a rising clock edge when
  // i_cmd_valid && o_cmd_ready; ready depends only on the registered fill
  // level and i_flush, never on i_cmd_valid.
  logic [CMD_W-1:0]   head;
  logic               fifo_full, fifo_empty;
  logic               push, pop, slot_free;
  state_e             state_q, state_d;
  logic [FRAME_W-1:0] remain_q, remain_d;
  logic [MIXER_W-1:0] mixer_q, mixer_d;

  assign o_cmd_ready = !fifo_full && !i_flush;
  assign push        = i_cmd_valid && o_cmd_ready;
  assign slot_free   = (state_q == IDLE) || (remain_q == '0);
  assign pop         = i_frame_pulse && !i_flush && !fifo_empty && slot_free;

  mixer_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_push  (push),
    .i_wdata ({i_cmd_frames, i_cmd_mask}),
    .i_pop   (pop),
    .o_rdata (head),
    .o_count (o_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    mixer_d  = mixer_q;
    if (i_flush) begin
      state_d  = IDLE;
      remain_d = '0;
      mixer_d  = DEFAULT_MASK;
    end else if (i_frame_pulse) begin
      if (pop) begin
        // Back-to-back commands chain here with no gap frame.
        mixer_d  = head[MIXER_W-1:0];
        remain_d = head[CMD_W-1:MIXER_W];
        state_d  = HOLD;
      end else if (state_q == HOLD) begin
        if (remain_q != '0) begin
          remain_d = remain_q - 1'b1;
        end else begin
          state_d = IDLE;
`ifdef APU_MIXER_SEQ_HOLD_LAST_EN
          mixer_d = mixer_q;
`else
          mixer_d = DEFAULT_MASK;
`endif
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      remain_q <= '0;
      mixer_q  <= DEFAULT_MASK;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      mixer_q  <= mixer_d;
    end
  end

  assign o_mixer = mixer_q;
  assign o_busy  = (state_q == HOLD) || (o_count != '0);

endmodule

// File: tb/tb_apu_mixer_sequencer.sv
// Self-checking bench for apu_mixer_sequencer: directed scenarios plus random
// traffic compared each cycle against a queue-based behavioural model.
module tb_apu_mixer_sequencer;

  localparam int         DEPTH = 4;
  localparam int         FW    = 8;
  localparam logic [3:0] DEF   = 4'b1111;

  logic          i_clk = 1'b0;
  logic          i_rst, i_flush, i_cmd_valid, i_frame_pulse;
  logic [3:0]    i_cmd_mask;
  logic [FW-1:0] i_cmd_frames;
  logic          o_cmd_ready, o_busy;
  logic [3:0]    o_mixer;
  logic [2:0]    o_count;

  apu_mixer_sequencer #(.DEPTH(DEPTH), .FRAME_W(FW), .DEFAULT_MASK(DEF)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_flush       (i_flush),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_mask    (i_cmd_mask),
    .i_cmd_frames  (i_cmd_frames),
    .i_frame_pulse (i_frame_pulse),
    .o_mixer       (o_mixer),
    .o_busy        (o_busy),
    .o_count       (o_count)
  );

  // Clock and reset
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: pending commands, current mask, frames left in the hold.
  typedef struct packed {
    logic [FW-1:0] frames;
    logic [3:0]    mask;
  } cmd_t;

  cmd_t       exp_q[$];
  cmd_t       m_cmd;
  logic [3:0] m_mask = DEF;
  bit         m_active = 1'b0;
  int         m_left = 0;
  int         m_sz;
  bit         m_rdy;

  always @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      exp_q.delete();
      m_mask   = DEF;
      m_active = 1'b0;
      m_left   = 0;
    end else begin
      m_sz  = exp_q.size();
      m_rdy = (m_sz != DEPTH);
      if (i_frame_pulse) begin
        if (m_active && m_left > 1) begin
          m_left = m_left - 1;
        end else if (m_sz != 0) begin
          m_cmd    = exp_q.pop_front();
          m_mask   = m_cmd.mask;
          m_left   = int'(m_cmd.frames) + 1;
          m_active = 1'b1;
        end else if (m_active) begin
          m_active = 1'b0;
          m_left   = 0;
`ifndef APU_MIXER_SEQ_HOLD_LAST_EN
          m_mask   = DEF;
`endif
        end
      end
      if (i_cmd_valid && m_rdy) exp_q.push_back({i_cmd_frames, i_cmd_mask});
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("mixer", 8'(o_mixer), 8'(m_mask));
      check("busy",  8'(o_busy),  8'(m_active || exp_q.size() != 0));
      check("count", 8'(o_count), 8'(exp_q.size()));
      if (!i_rst) check("ready", 8'(o_cmd_ready), 8'((exp_q.size() != DEPTH) && !i_flush));
    end
  end

  // Literal pin: checks both the DUT and the model against a hand value.
  task automatic pin(input string name, input logic [7:0] dut_v, input logic [7:0] mdl_v,
                     input logic [7:0] lit);
    check({name, "_dut"}, dut_v, lit);
    check({name, "_model"}, mdl_v, lit);
  endtask

  // Driver: apply inputs for one cycle, return just after the edge that samples them.
  task automatic tick(input logic v, input logic [3:0] m, input logic [FW-1:0] f,
                      input logic p, input logic fl, input logic r);
    i_cmd_valid   = v;
    i_cmd_mask    = m;
    i_cmd_frames  = f;
    i_frame_pulse = p;
    i_flush       = fl;
    i_rst         = r;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse();
    tick(1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  logic [3:0] seq3 [5];

  initial begin
    tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;

    // Reset state and pulses with nothing queued
    idle();
    pin("rst_mixer", 8'(o_mixer), 8'(m_mask), 8'hF);
    pin("rst_count", 8'(o_count), 8'(exp_q.size()), 8'h0);
    for (int i = 0; i < 3; i++) pulse();
    pin("nocmd_mixer", 8'(o_mixer), 8'(m_mask), 8'hF);
    pin("nocmd_busy", 8'(o_busy), 8'(m_active), 8'h0);
    pin("nocmd_ready", 8'(o_cmd_ready), 8'(exp_q.size() != DEPTH), 8'h1);

    // Single command held three frames
    tick(1'b1, 4'b0001, 8'd2, 1'b0, 1'b0, 1'b0);
    idle();
    pulse();
    pin("p1_mixer", 8'(o_mixer), 8'(m_mask), 8'h1);
    pulse();
    pulse();
    pin("p3_mixer", 8'(o_mixer), 8'(m_mask), 8'h1);
    pulse();
    pin("p4_mixer", 8'(o_mixer), 8'(m_mask), 8'hF);
    pin("p4_busy", 8'(o_busy), 8'(m_active), 8'h0);

    // Three chained commands with no gap frames
    tick(1'b1, 4'b0011, 8'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'b0101, 8'd1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'b1000, 8'd0, 1'b0, 1'b0, 1'b0);
    seq3[0] = 4'b0011; seq3[1] = 4'b0101; seq3[2] = 4'b0101;
    seq3[3] = 4'b1000; seq3[4] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      pulse();
      pin($sformatf("chain%0d", i), 8'(o_mixer), 8'(m_mask), 8'(seq3[i]));
    end

    // Fill the queue, fifth push held off
    for (int i = 1; i <= 4; i++) tick(1'b1, 4'(i), 8'd0, 1'b0, 1'b0, 1'b0);
    pin("full_count", 8'(o_count), 8'(exp_q.size()), 8'h4);
    i_cmd_valid = 1'b1;
    i_cmd_mask  = 4'd5;
    #1;
    pin("full_ready", 8'(o_cmd_ready), 8'(exp_q.size() != DEPTH), 8'h0);
    @(posedge i_clk);
    #1;
    tick(1'b1, 4'd5, 8'd0, 1'b1, 1'b0, 1'b0);
    pin("pop_count", 8'(o_count), 8'(exp_q.size()), 8'h3);
    pin("pop_ready", 8'(o_cmd_ready), 8'(exp_q.size() != DEPTH), 8'h1);
    pin("pop_mixer", 8'(o_mixer), 8'(m_mask), 8'h1);
    pulse();
    pin("pop2_count", 8'(o_count), 8'(exp_q.size()), 8'h2);

    // Flush mid-hold with a push and a pulse in the same cycle
    tick(1'b1, 4'b1010, 8'd3, 1'b1, 1'b1, 1'b0);
    pin("flush_count", 8'(o_count), 8'(exp_q.size()), 8'h0);
    pin("flush_mixer", 8'(o_mixer), 8'(m_mask), 8'hF);
    pin("flush_busy", 8'(o_busy), 8'(m_active), 8'h0);
    idle();
    pin("flush_drop", 8'(o_count), 8'(exp_q.size()), 8'h0);

    // Expiry of the last command
    tick(1'b1, 4'b0110, 8'd0, 1'b0, 1'b0, 1'b0);
    pulse();
    pin("last_p1", 8'(o_mixer), 8'(m_mask), 8'h6);
    pulse();
    pulse();
`ifdef APU_MIXER_SEQ_HOLD_LAST_EN
    pin("last_keep", 8'(o_mixer), 8'(m_mask), 8'h6);
`else
    pin("last_revert", 8'(o_mixer), 8'(m_mask), 8'hF);
`endif
    tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    pin("last_rst", 8'(o_mixer), 8'(m_mask), 8'hF);

    // Reset mid-hold aborts the command
    tick(1'b1, 4'b0010, 8'd5, 1'b0, 1'b0, 1'b0);
    pulse();
    tick(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    pin("rst_hold", 8'(o_mixer), 8'(m_mask), 8'hF);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [FW-1:0] f;
      r = $urandom_range(0, 19);
      f = (r == 0) ? 8'hFF : 8'(r % 4);
      tick($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), f,
           $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 99) == 0);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
